// File: rtl/cpu_defs_pkg.sv
// Shared core definitions: opcodes decoded by the write-back mux and the store path,
// default datapath widths, and the store buffer FSM encoding.
package cpu_defs_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  localparam logic [3:0] OP_ALU   = 4'd1;
  localparam logic [3:0] OP_IMM   = 4'd2;
  localparam logic [3:0] OP_LOAD  = 4'd10;
  localparam logic [3:0] OP_STORE = 4'd11;

  typedef enum logic {SB_IDLE, SB_REQ} sb_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Occupancy-counted FIFO; exposes the head and the entry behind it so the owner can
// reload its output registers on the same edge it pops.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic [W-1:0]  nxt,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
  assign rd_ptr_nxt = rd_ptr + AW'(1);
  assign head       = mem[rd_ptr];
  assign nxt        = mem[rd_ptr_nxt];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Queues STORE requests and drains them in order to the memory write port over a
// req/ack handshake; the core only sees stall.
module store_buffer
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en,
  input  logic [3:0]        op_code,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              empty,
  output logic [CW-1:0]     count
);
  localparam int EW = ADDR_W + DATA_W;

  sb_state_t   state;
  logic        push, pop;
  logic [EW-1:0] head, nxt;

  // No bypass: a full buffer refuses a push even when the head pops this cycle.
  assign stall = (count == CW'(DEPTH));
  assign push  = issue_en && (op_code == OP_STORE) && !stall;
  assign pop   = (state == SB_REQ) && wr_ack;
  assign empty = (count == '0) && (state == SB_IDLE);

  sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({st_addr, st_data}),
    .head  (head),
    .nxt   (nxt),
    .count (count)
  );

  // The head stays in the FIFO while in flight; it is popped only on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SB_IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      case (state)
        SB_IDLE: begin
          if (count != '0) begin
            {wr_addr, wr_data} <= head;
            wr_en              <= 1'b1;
            state              <= SB_REQ;
          end
        end
        SB_REQ: begin
          if (wr_ack) begin
            if (count > CW'(1)) begin
              {wr_addr, wr_data} <= nxt;
            end else begin
              wr_en <= 1'b0;
              state <= SB_IDLE;
            end
          end
        end
        default: begin
          wr_en <= 1'b0;
          state <= SB_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench: stimulus pushes expected writes into a queue; a negedge monitor
// pops and compares every acked write and checks addr/data stay frozen while held.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_en = 1'b0;
  logic [3:0]  op_code = 4'd0;
  logic [15:0] st_addr = '0, st_data = '0;
  logic        wr_ack = 1'b0;
  logic        stall, wr_en, empty;
  logic [15:0] wr_addr, wr_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        hold_v = 1'b0;
  logic [31:0] hold_val = '0;

  store_buffer dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .op_code(op_code),
    .st_addr(st_addr), .st_data(st_data), .stall(stall), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .empty(empty),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d, input bit accept);
    issue_en = 1'b1;
    op_code  = 4'd11;
    st_addr  = a;
    st_data  = d;
    if (accept) exp_q.push_back({a, d});
    tick();
    issue_en = 1'b0;
    op_code  = 4'd0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    wr_ack = 1'b1;
    while (!empty && n < 30) begin
      tick();
      n++;
    end
    wr_ack = 1'b0;
    chk(name, {31'd0, empty}, 32'd1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n || !wr_en) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("hold_stable", {wr_addr, wr_data}, hold_val);
      if (wr_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got %0h expected none", {wr_addr, wr_data});
        end else begin
          chk("wr_order", {wr_addr, wr_data}, exp_q.pop_front());
        end
        hold_v = 1'b0;
      end else begin
        hold_v   = 1'b1;
        hold_val = {wr_addr, wr_data};
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_wr_addr", {16'd0, wr_addr}, 0);
    rst_n = 1'b1;
    tick();

    // 1: async reset mid-REQ drops the in-flight write
    store(16'h0100, 16'h0007, 1'b0);
    tick();
    chk("t1_in_req", {31'd0, wr_en}, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t1_async_wr_en", {31'd0, wr_en}, 0);
    chk("t1_async_count", {29'd0, count}, 0);
    chk("t1_async_empty", {31'd0, empty}, 1);
    tick();
    rst_n  = 1'b1;
    wr_ack = 1'b1;
    repeat (4) tick();
    chk("t1_no_reissue", {31'd0, wr_en}, 0);
    wr_ack = 1'b0;

    // 2: single store, ack after 3 cycles of request
    store(16'h0040, 16'h002D, 1'b1);
    chk("t2_lat0_wr_en", {31'd0, wr_en}, 0);
    chk("t2_count", {29'd0, count}, 1);
    tick();
    chk("t2_wr_en", {31'd0, wr_en}, 1);
    chk("t2_wr_addr", {16'd0, wr_addr}, 32'h0040);
    chk("t2_wr_data", {16'd0, wr_data}, 32'h002D);
    tick();
    tick();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("t2_idle_wr_en", {31'd0, wr_en}, 0);
    chk("t2_empty", {31'd0, empty}, 1);

    // 3: non-store opcodes and store without issue_en
    issue_en = 1'b1; op_code = 4'd10; st_addr = 16'h0050; st_data = 16'h0001;
    tick();
    op_code = 4'd1;
    tick();
    issue_en = 1'b0; op_code = 4'd11;
    tick();
    op_code = 4'd0;
    tick();
    chk("t3_count", {29'd0, count}, 0);
    chk("t3_wr_en", {31'd0, wr_en}, 0);

    // 4: fill with ack held low; fifth store dropped
    store(16'h0010, 16'd45, 1'b1);
    store(16'h0011, 16'd55, 1'b1);
    store(16'h0012, 16'd115, 1'b1);
    store(16'h0013, 16'd1, 1'b1);
    chk("t4_count_full", {29'd0, count}, 4);
    chk("t4_stall", {31'd0, stall}, 1);
    store(16'h0014, 16'd2, 1'b0);
    chk("t4_count_after_drop", {29'd0, count}, 4);
    drain("t4_drain_empty");
    chk("t4_stall_clear", {31'd0, stall}, 0);

    // 5: back-to-back with ack held high
    store(16'h0020, 16'h00A1, 1'b1);
    store(16'h0021, 16'h00A2, 1'b1);
    store(16'h0022, 16'h00A3, 1'b1);
    chk("t5_count3", {29'd0, count}, 3);
    chk("t5_wr_en3", {31'd0, wr_en}, 1);
    wr_ack = 1'b1;
    tick();
    chk("t5_count2", {29'd0, count}, 2);
    chk("t5_wr_en2", {31'd0, wr_en}, 1);
    tick();
    chk("t5_count1", {29'd0, count}, 1);
    chk("t5_wr_en1", {31'd0, wr_en}, 1);
    tick();
    chk("t5_count0", {29'd0, count}, 0);
    chk("t5_wr_en0", {31'd0, wr_en}, 0);
    wr_ack = 1'b0;

    // 6a: full + ack + push in one cycle -> push ignored
    store(16'h0030, 16'h0B01, 1'b1);
    store(16'h0031, 16'h0B02, 1'b1);
    store(16'h0032, 16'h0B03, 1'b1);
    store(16'h0033, 16'h0B04, 1'b1);
    chk("t6a_stall", {31'd0, stall}, 1);
    wr_ack = 1'b1;
    store(16'h0099, 16'h0BFF, 1'b0);
    wr_ack = 1'b0;
    chk("t6a_count3", {29'd0, count}, 3);
    drain("t6a_drain_empty");

    // 6b: count=2, ack + push together -> count stays 2, order kept
    store(16'h0060, 16'h0C01, 1'b1);
    store(16'h0061, 16'h0C02, 1'b1);
    chk("t6b_count2_pre", {29'd0, count}, 2);
    wr_ack = 1'b1;
    store(16'h0062, 16'h0C03, 1'b1);
    wr_ack = 1'b0;
    chk("t6b_count2_post", {29'd0, count}, 2);
    drain("t6b_drain_empty");

    tick();
    chk("all_writes_seen", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
